// File: rtl/fpu_pipe.sv
// Parametrised 1/EXP_W/MAN_W floating-point unit: addf, subf, mulf, itof, ftoi.
// Latency: 3 cycles from in-transfer to out_valid, throughput 1/cycle; holds up to 3 ops.
// Backpressure: stages stall back from out_ready; in_ready = !s1_valid || stage 1 advancing.
module fpu_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 7,
  parameter int TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           in_op,
  input  logic [EXP_W+MAN_W:0] in_a,
  input  logic [EXP_W+MAN_W:0] in_b,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] out_data,
  output logic [TAG_W-1:0]     out_tag,
  output logic                 out_zero,
  output logic                 out_ovf,
  output logic                 out_unf
);

  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam int MW   = MAN_W + 1;             // mantissa with hidden one
  localparam int PW   = 2 * MW;                // full product width
  localparam int NW   = (PW > W) ? PW : W;     // common normalisation width
  localparam int EW   = EXP_W + 8;             // signed working exponent width
  localparam int LZW  = $clog2(NW + 1);
  localparam logic [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_MUL  = 3'd2;
  localparam logic [2:0] OP_ITOF = 3'd3;
  localparam logic [2:0] OP_FTOI = 3'd4;

  // Leading-zero count over the common normalisation width.
  function automatic logic [LZW-1:0] lzc(input logic [NW-1:0] v);
    logic [LZW-1:0] n;
    logic           found;
    n     = '0;
    found = 1'b0;
    for (int i = NW - 1; i >= 0; i--) begin
      if (!found) begin
        if (v[i]) found = 1'b1;
        else      n = n + LZW'(1);
      end
    end
    return n;
  endfunction

  // Pipeline state
  logic            s1_valid, s2_valid;
  logic [2:0]      s1_op, s2_op;
  logic [TAG_W-1:0] s1_tag, s2_tag;
  logic            s1_sign, s2_sign;
  logic [EXP_W-1:0] s1_ea, s1_eb;
  logic [MW-1:0]   s1_ma, s1_mb;
  logic            s1_sub;
  logic [W-1:0]    s1_int;
  logic [EW-1:0]   s1_ue;
  logic            s1_fz;
  logic [NW-1:0]   s2_m;
  logic [EW-1:0]   s2_e;
  logic [W-1:0]    s2_int;
  logic            s2_sat;

  logic adv1, adv2;

  // Stage k moves on when its successor is empty or itself moving.
  assign adv2     = !out_valid || out_ready;
  assign adv1     = !s2_valid || adv2;
  assign in_ready = !s1_valid || adv1;

  // ---------------- Stage 1: unpack / align ----------------
  logic            a_sign, b_sign, a_big;
  logic [EXP_W-1:0] a_exp, b_exp;
  logic [MW-1:0]   a_man, b_man;
  logic            n1_sign, n1_sub, n1_fz;
  logic [EXP_W-1:0] n1_ea, n1_eb;
  logic [MW-1:0]   n1_ma, n1_mb;
  logic [W-1:0]    n1_int;
  logic [EW-1:0]   n1_ue;

  // Split operands (denormals flush to zero), order add operands by magnitude.
  always_comb begin
    a_sign  = in_a[W-1];
    a_exp   = in_a[W-2 -: EXP_W];
    a_man   = (a_exp == '0) ? '0 : {1'b1, in_a[MAN_W-1:0]};
    b_sign  = in_b[W-1] ^ (in_op == OP_SUB);
    b_exp   = in_b[W-2 -: EXP_W];
    b_man   = (b_exp == '0) ? '0 : {1'b1, in_b[MAN_W-1:0]};
    a_big   = {a_exp, a_man} >= {b_exp, b_man};
    n1_sign = 1'b0;
    n1_sub  = 1'b0;
    n1_fz   = 1'b0;
    n1_ea   = '0;
    n1_eb   = '0;
    n1_ma   = '0;
    n1_mb   = '0;
    n1_int  = '0;
    n1_ue   = '0;
    case (in_op)
      OP_ADD, OP_SUB: begin
        // Shifting past MAN_W+1 places empties the smaller mantissa entirely.
        n1_sub = a_sign ^ b_sign;
        if (a_big) begin
          n1_sign = a_sign;
          n1_ea   = a_exp;
          n1_ma   = a_man;
          n1_mb   = b_man >> (a_exp - b_exp);
        end else begin
          n1_sign = b_sign;
          n1_ea   = b_exp;
          n1_ma   = b_man;
          n1_mb   = a_man >> (b_exp - a_exp);
        end
      end
      OP_MUL: begin
        n1_sign = a_sign ^ b_sign;
        n1_ea   = a_exp;
        n1_eb   = b_exp;
        n1_ma   = a_man;
        n1_mb   = b_man;
      end
      OP_ITOF: begin
        // W-bit unsigned magnitude covers the most-negative integer as 2^(W-1).
        n1_sign = in_b[W-1];
        n1_int  = in_b[W-1] ? -in_b : in_b;
      end
      OP_FTOI: begin
        n1_sign = in_b[W-1];
        n1_ma   = b_man;
        n1_fz   = (b_exp == '0);
        n1_ue   = EW'(b_exp) - EW'(BIAS);
      end
      default: ;
    endcase
  end

  // Stage 1 register: loads whenever the unit can accept.
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_valid <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_op   <= in_op;
        s1_tag  <= in_tag;
        s1_sign <= n1_sign;
        s1_sub  <= n1_sub;
        s1_fz   <= n1_fz;
        s1_ea   <= n1_ea;
        s1_eb   <= n1_eb;
        s1_ma   <= n1_ma;
        s1_mb   <= n1_mb;
        s1_int  <= n1_int;
        s1_ue   <= n1_ue;
      end
    end
  end

  // ---------------- Stage 2: compute ----------------
  // Float results leave here as a left-aligned NW-bit mantissa whose MSB has
  // biased exponent n2_e; stage 3 only needs to normalise and pack.
  logic [MW:0]     sum;
  logic [PW-1:0]   prod;
  logic [NW-1:0]   ext;
  logic [LZW-1:0]  lz2;
  logic [NW-1:0]   n2_m;
  logic [EW-1:0]   n2_e;
  logic [W-1:0]    n2_int;
  logic            n2_sat;

  // Magnitude add/sub, product, integer normalise and float-to-int shift.
  always_comb begin
    sum    = '0;
    prod   = '0;
    ext    = '0;
    lz2    = '0;
    n2_m   = '0;
    n2_e   = '0;
    n2_int = '0;
    n2_sat = 1'b0;
    case (s1_op)
      OP_ADD, OP_SUB: begin
        sum  = s1_sub ? ({1'b0, s1_ma} - {1'b0, s1_mb}) : ({1'b0, s1_ma} + {1'b0, s1_mb});
        n2_m = NW'(sum) << (NW - MW - 1);
        n2_e = EW'(s1_ea) + EW'(1);
      end
      OP_MUL: begin
        prod = PW'(s1_ma) * PW'(s1_mb);
        n2_m = NW'(prod) << (NW - PW);
        n2_e = EW'(s1_ea) + EW'(s1_eb) - EW'(BIAS) + EW'(1);
      end
      OP_ITOF: begin
        ext  = NW'(s1_int) << (NW - W);
        lz2  = lzc(ext);
        n2_m = ext << lz2;
        n2_e = EW'(BIAS + W - 1) - EW'(lz2);
      end
      OP_FTOI: begin
        if (s1_fz || s1_ue[EW-1])         n2_int = '0;
        else if (s1_ue >= EW'(W - 1))     n2_sat = 1'b1;
        else if (s1_ue >= EW'(MAN_W))     n2_int = W'(s1_ma) << (s1_ue - EW'(MAN_W));
        else                              n2_int = W'(s1_ma) >> (EW'(MAN_W) - s1_ue);
      end
      default: ;
    endcase
  end

  // Stage 2 register: advances when the output stage can take it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      s2_valid <= 1'b0;
    end else if (adv1) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_op   <= s1_op;
        s2_tag  <= s1_tag;
        s2_sign <= s1_sign;
        s2_m    <= n2_m;
        s2_e    <= n2_e;
        s2_int  <= n2_int;
        s2_sat  <= n2_sat;
      end
    end
  end

  // ---------------- Stage 3: normalise / pack ----------------
  logic [LZW-1:0]  lz3;
  logic [EW-1:0]   e3;
  logic [MAN_W-1:0] man3;
  logic [W-1:0]    n3_data;
  logic            n3_zero, n3_ovf, n3_unf;

  // Truncating normalise with overflow/underflow clamps; integer sign/saturate.
  always_comb begin
    lz3     = lzc(s2_m);
    e3      = s2_e - EW'(lz3);
    man3    = MAN_W'((s2_m << lz3) >> (NW - 1 - MAN_W));
    n3_data = '0;
    n3_zero = 1'b0;
    n3_ovf  = 1'b0;
    n3_unf  = 1'b0;
    case (s2_op)
      OP_ADD, OP_SUB, OP_MUL, OP_ITOF: begin
        if (s2_m == '0) begin
          n3_data = '0;
        end else if (!e3[EW-1] && (e3 >= EMAX)) begin
          n3_data = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          n3_ovf  = 1'b1;
        end else if (e3[EW-1] || (e3 == '0)) begin
          n3_data = '0;
          n3_unf  = 1'b1;
        end else begin
          n3_data = {s2_sign, e3[EXP_W-1:0], man3};
        end
        n3_zero = (n3_data[W-2 -: EXP_W] == '0);
      end
      OP_FTOI: begin
        if (s2_sat) begin
          n3_data = s2_sign ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
          n3_ovf  = 1'b1;
        end else begin
          n3_data = s2_sign ? -s2_int : s2_int;
        end
        n3_zero = (n3_data == '0);
      end
      default: begin
        n3_data = '0;
        n3_ovf  = 1'b1;
        n3_zero = 1'b1;
      end
    endcase
  end

  // Output register: holds while out_valid && !out_ready.
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= '0;
      out_zero  <= 1'b0;
      out_ovf   <= 1'b0;
      out_unf   <= 1'b0;
    end else if (adv2) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        out_data <= n3_data;
        out_tag  <= s2_tag;
        out_zero <= n3_zero;
        out_ovf  <= n3_ovf;
        out_unf  <= n3_unf;
      end
    end
  end

endmodule

// File: tb/tb_fpu_pipe.sv
// Directed bench for fpu_pipe: default format plus an EXP_W=5/MAN_W=10 instance.
// Both instances share inputs; sel picks which outputs the single-op checks read.
module tb_fpu_pipe;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [2:0]  in_op;
  logic [15:0] in_a, in_b;
  logic [3:0]  in_tag;
  logic        out_ready;

  logic        d_in_ready, d_out_valid, d_out_zero, d_out_ovf, d_out_unf;
  logic [15:0] d_out_data;
  logic [3:0]  d_out_tag;
  logic        s_in_ready, s_out_valid, s_out_zero, s_out_ovf, s_out_unf;
  logic [15:0] s_out_data;
  logic [3:0]  s_out_tag;

  int compared   = 0;
  int mismatched = 0;
  logic sel = 1'b0;

  fpu_pipe u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(d_in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(d_out_valid), .out_ready(out_ready), .out_data(d_out_data),
    .out_tag(d_out_tag), .out_zero(d_out_zero), .out_ovf(d_out_ovf), .out_unf(d_out_unf)
  );

  fpu_pipe #(.EXP_W(5), .MAN_W(10), .TAG_W(4)) u_sw (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
    .out_tag(s_out_tag), .out_zero(s_out_zero), .out_ovf(s_out_ovf), .out_unf(s_out_unf)
  );

  logic        c_valid, c_zero, c_ovf, c_unf;
  logic [15:0] c_data;
  logic [3:0]  c_tag;
  assign c_valid = sel ? s_out_valid : d_out_valid;
  assign c_data  = sel ? s_out_data  : d_out_data;
  assign c_tag   = sel ? s_out_tag   : d_out_tag;
  assign c_zero  = sel ? s_out_zero  : d_out_zero;
  assign c_ovf   = sel ? s_out_ovf   : d_out_ovf;
  assign c_unf   = sel ? s_out_unf   : d_out_unf;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Offer one op with out_ready=1, then check latency, data, tag and flags.
  task automatic run1(input string nm, input logic [2:0] op, input logic [15:0] a,
                      input logic [15:0] b, input logic [3:0] tag, input logic [15:0] ed,
                      input logic eo, input logic eu, input logic ez);
    int n;
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
    #1;
    n = 0;
    while (!d_in_ready && n < 10) begin @(negedge clk); n++; end
    chk({nm, "_accept"}, {31'd0, d_in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    while (!c_valid && n < 10) begin @(negedge clk); n++; end
    chk({nm, "_latency"}, n, 32'd3);
    chk({nm, "_data"}, {16'd0, c_data}, {16'd0, ed});
    chk({nm, "_tag"},  {28'd0, c_tag},  {28'd0, tag});
    chk({nm, "_ovf"},  {31'd0, c_ovf},  {31'd0, eo});
    chk({nm, "_unf"},  {31'd0, c_unf},  {31'd0, eu});
    chk({nm, "_zero"}, {31'd0, c_zero}, {31'd0, ez});
    @(negedge clk);
  endtask

  logic [2:0]  bp_op [1:6];
  logic [15:0] bp_a  [1:6];
  logic [15:0] bp_b  [1:6];
  logic [15:0] bp_d  [1:6];

  initial begin
    int ti, to, extra, stale;
    logic acc;
    reset = 1'b0; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; in_tag = '0;
    out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", {31'd0, d_out_valid}, 32'd0);
    chk("rst_data",  {16'd0, d_out_data}, 32'd0);
    chk("rst_tag",   {28'd0, d_out_tag}, 32'd0);
    chk("rst_flags", {29'd0, d_out_zero, d_out_ovf, d_out_unf}, 32'd0);
    chk("rst_in_ready", {31'd0, d_in_ready}, 32'd1);
    chk("rst_sw_valid", {31'd0, s_out_valid}, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Main function, default format
    run1("addf",      3'd0, 16'h3F80, 16'h4000, 4'd1, 16'h4040, 1'b0, 1'b0, 1'b0);
    run1("subf_zero", 3'd1, 16'h3FC0, 16'h3FC0, 4'd2, 16'h0000, 1'b0, 1'b0, 1'b1);
    run1("addf_mix",  3'd0, 16'h4040, 16'hBF80, 4'd3, 16'h4000, 1'b0, 1'b0, 1'b0);
    run1("addf_d7",   3'd0, 16'h4300, 16'h3F80, 4'd4, 16'h4301, 1'b0, 1'b0, 1'b0);
    run1("addf_far",  3'd0, 16'h4B00, 16'h3F80, 4'd5, 16'h4B00, 1'b0, 1'b0, 1'b0);
    run1("mulf",      3'd2, 16'h3FC0, 16'h4000, 4'd6, 16'h4040, 1'b0, 1'b0, 1'b0);
    run1("mulf_ovf",  3'd2, 16'h7F00, 16'h4000, 4'd7, 16'h7F80, 1'b1, 1'b0, 1'b0);
    run1("mulf_unf",  3'd2, 16'h0080, 16'h0080, 4'd8, 16'h0000, 1'b0, 1'b1, 1'b1);
    run1("itof_5",    3'd3, 16'h0000, 16'h0005, 4'd9, 16'h40A0, 1'b0, 1'b0, 1'b0);
    run1("itof_m3",   3'd3, 16'h0000, 16'hFFFD, 4'd10, 16'hC040, 1'b0, 1'b0, 1'b0);
    run1("itof_min",  3'd3, 16'h0000, 16'h8000, 4'd11, 16'hC700, 1'b0, 1'b0, 1'b0);
    run1("itof_0",    3'd3, 16'h0000, 16'h0000, 4'd12, 16'h0000, 1'b0, 1'b0, 1'b1);
    run1("ftoi_m3",   3'd4, 16'h0000, 16'hC040, 4'd13, 16'hFFFD, 1'b0, 1'b0, 1'b0);
    run1("ftoi_sat",  3'd4, 16'h0000, 16'h7F00, 4'd14, 16'h7FFF, 1'b1, 1'b0, 1'b0);
    run1("ftoi_half", 3'd4, 16'h0000, 16'h3F00, 4'd15, 16'h0000, 1'b0, 1'b0, 1'b1);
    run1("reserved",  3'd7, 16'h1234, 16'h5678, 4'd9, 16'h0000, 1'b1, 1'b0, 1'b1);

    // Back-pressure: 5 ops offered while out_ready=0, then drained
    bp_op[1] = 3'd0; bp_a[1] = 16'h3F80; bp_b[1] = 16'h4000; bp_d[1] = 16'h4040;
    bp_op[2] = 3'd2; bp_a[2] = 16'h3FC0; bp_b[2] = 16'h4000; bp_d[2] = 16'h4040;
    bp_op[3] = 3'd3; bp_a[3] = 16'h0000; bp_b[3] = 16'h0005; bp_d[3] = 16'h40A0;
    bp_op[4] = 3'd4; bp_a[4] = 16'h0000; bp_b[4] = 16'hC040; bp_d[4] = 16'hFFFD;
    bp_op[5] = 3'd0; bp_a[5] = 16'h4040; bp_b[5] = 16'hBF80; bp_d[5] = 16'h4000;
    bp_op[6] = 3'd0; bp_a[6] = 16'h0000; bp_b[6] = 16'h0000; bp_d[6] = 16'h0000;
    out_ready = 1'b0;
    ti = 1; to = 1; extra = 0;
    for (int c = 0; c < 17; c++) begin
      if (c == 5) begin
        chk("bp_accepted", ti - 1, 32'd3);
        chk("bp_in_ready", {31'd0, d_in_ready}, 32'd0);
        chk("bp_hold_tag", {28'd0, d_out_tag}, 32'd1);
        chk("bp_hold_data", {16'd0, d_out_data}, 32'h4040);
        out_ready = 1'b1;
      end
      in_valid = (ti <= 5);
      in_op = bp_op[ti]; in_a = bp_a[ti]; in_b = bp_b[ti]; in_tag = 4'(ti);
      #1;
      acc = in_valid && d_in_ready;
      if (d_out_valid && out_ready) begin
        if (to <= 5) begin
          chk("bp_tag", {28'd0, d_out_tag}, to);
          chk("bp_data", {16'd0, d_out_data}, {16'd0, bp_d[to]});
        end else begin
          extra++;
        end
        to++;
      end
      @(posedge clk);
      if (acc) ti++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("bp_drained", to, 32'd6);
    chk("bp_extra", extra, 32'd0);

    // Reset with three ops in flight
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_op = (k == 0) ? 3'd2 : 3'd0;
      in_a  = (k == 0) ? 16'h7F00 : 16'h3F80;
      in_b  = 16'h4000;
      in_tag = 4'(11 + k);
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("rmf_pre_valid", {31'd0, d_out_valid}, 32'd1);
    chk("rmf_pre_ovf", {31'd0, d_out_ovf}, 32'd1);
    chk("rmf_pre_in_ready", {31'd0, d_in_ready}, 32'd0);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    chk("rmf_valid", {31'd0, d_out_valid}, 32'd0);
    chk("rmf_flags", {29'd0, d_out_zero, d_out_ovf, d_out_unf}, 32'd0);
    chk("rmf_data", {16'd0, d_out_data}, 32'd0);
    chk("rmf_in_ready", {31'd0, d_in_ready}, 32'd1);
    out_ready = 1'b1;
    stale = 0;
    for (int k = 0; k < 6; k++) begin
      if (d_out_valid) stale++;
      @(negedge clk);
    end
    chk("rmf_stale", stale, 32'd0);
    run1("post_rst", 3'd0, 16'h3F80, 16'h4000, 4'd6, 16'h4040, 1'b0, 1'b0, 1'b0);

    // Parameter sweep instance: EXP_W=5, MAN_W=10
    sel = 1'b1;
    run1("sw_addf", 3'd0, 16'h3C00, 16'h3C00, 4'd2, 16'h4000, 1'b0, 1'b0, 1'b0);
    run1("sw_itof", 3'd3, 16'h0000, 16'h0003, 4'd3, 16'h4200, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fpu_pipe.md
Name: fpu_pipe

Overview:
- Parametrised, handshaked floating-point execution unit that replaces the fixed-width inline float stage in the core.
- Implements addf and subf, which the current core lacks, plus mulf, itof and ftoi, on a generic 1/EXP_W/MAN_W format.
- Sits between the decode/operand-read stage and writeback.
- Three-stage stallable pipeline carrying a destination tag, with a valid/ready handshake on both sides.

Parameters:
- EXP_W, 8, exponent width. Bias = 2^(EXP_W-1)-1.
- MAN_W, 7, stored mantissa width, hidden 1 implied. Word width W = 1+EXP_W+MAN_W. Integers are W-bit two's complement.
- TAG_W, 4, width of the passthrough tag (destination register).

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-low reset; reset==0 at posedge clears the unit.
- in_valid  in  1  operation offered.
- in_ready  out  1  unit accepts this cycle.
- in_op  in  3  0=addf 1=subf 2=mulf 3=itof 4=ftoi; 5-7 reserved.
- in_a  in  W  operand A (float; unused for itof/ftoi).
- in_b  in  W  operand B (float, or integer for itof).
- in_tag  in  TAG_W  passthrough tag.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts.
- out_data  out  W  result.
- out_tag  out  TAG_W  tag of result.
- out_zero  out  1  out_data is zero (Z-flag source for .S instructions).
- out_ovf  out  1  exponent overflow or integer saturation occurred.
- out_unf  out  1  result flushed to zero by underflow.

Behaviour:
- Reset (reset==0 at posedge):
  - All stage valid bits cleared.
  - out_valid=0, out_data=0, out_tag=0, out_zero=0, out_ovf=0, out_unf=0.
  - A reset mid-operation discards in-flight results; none is emitted afterwards.
- Handshake:
  - Transfer in on posedge when in_valid&&in_ready.
  - Transfer out on posedge when out_valid&&out_ready.
  - in_ready = !s1_valid || advance1, where stage k advances if its successor is empty or advancing. The last stage advances on out_ready.
  - No combinational path from in_valid to out_valid. in_ready may depend combinationally on out_ready.
  - Outputs hold stable while out_valid && !out_ready.
- Latency:
  - With out_ready held 1: 3 cycles in to out_valid, throughput 1/cycle, no bubbles.
  - Pipeline holds at most 3 operations. Full with out_ready=0 gives in_ready=0.
  - Simultaneous in- and out-transfer when full is legal, and occupancy stays 3.
- Stage 1, unpack/align:
  - Split sign/exp/mantissa. Exponent 0 means zero: denormals flush to zero, mantissa ignored.
  - Exponent all-ones operands are treated as finite.
  - subf inverts B's sign, then proceeds as addf.
  - addf: order by magnitude and right-shift the smaller mantissa by the exponent difference. Differences > MAN_W+1 give a zero contribution.
  - itof: take the absolute value; the most-negative integer is handled as magnitude 2^(W-1).
  - ftoi: compute unbiased exponent.
- Stage 2, compute:
  - add/sub: magnitude add if signs are equal, else larger minus smaller, using MAN_W+2-bit datapath.
  - mulf: (MAN_W+1)x(MAN_W+1) product; exponent = eA+eB-bias.
  - itof and ftoi use the leading-zero count and shift here.
- Stage 3, normalise/pack:
  - Leading-zero normalise; rounding is truncation throughout.
  - Exponent >= 2^EXP_W-1: result is sign|all-ones exp|zero mantissa, out_ovf=1.
  - Exponent <= 0: result +0, out_unf=1.
  - Exact zero result (including x-x): +0, out_unf=0.
  - ftoi truncates toward zero. |value| >= 2^(W-1) saturates to 2^(W-1)-1 or -2^(W-1) with out_ovf=1. Unbiased exponent < 0 gives 0.
  - out_zero = (out_data==0) for integer results; for float results, exp field == 0.
- Reserved op codes: result 0, out_ovf=1, tag still passed through; the pipeline does not stall.

Test Plan:
- Default params, out_ready=1:
  - addf 0x3F80+0x4000 -> 0x4040 three cycles after acceptance.
  - subf 0x3FC0-0x3FC0 -> 0x0000, out_zero=1.
- mulf:
  - 0x3FC0*0x4000 -> 0x4040.
  - 0x7F00*0x4000 -> 0x7F80, out_ovf=1.
  - 0x0080*0x0080 -> 0x0000, out_unf=1.
- Conversions:
  - itof 5 -> 0x40A0.
  - itof 0xFFFD -> 0xC040.
  - itof 0x8000 -> 0xC700.
  - ftoi 0xC040 -> 0xFFFD.
  - ftoi 0x7F00 -> 0x7FFF, out_ovf=1.
- Back-pressure:
  - Issue 5 ops with tags 1..5 while out_ready=0: exactly 3 accepted, in_ready drops.
  - Raise out_ready: tags 1..5 emerge in order with correct data; none lost or duplicated.
- Reset mid-flight:
  - Assert reset=0 for one cycle with 3 ops in flight: out_valid=0 and flags 0 next cycle.
  - No stale result appears afterwards; a new op after reset returns in 3 cycles.
- Parameter sweep, EXP_W=5 MAN_W=10 (W=16, bias 15):
  - addf 0x3C00+0x3C00 -> 0x4000.
  - itof 3 -> 0x4200.
